mul_div_unit: RTL and testbench

Iterative 32-bit multiply/divide unit implementing the RV32M operations. It sits beside the combinational ALU in the execute stage and receives the same operand pair. Where the ALU returns a result in the same cycle, this unit accepts a request under a start/busy/done handshake and returns a registered result after a fixed latency. It uses one shared shift-add / restoring-divide datapath.

---
 rtl/mul_div_unit.sv | 167 ++++++++++++++++
 tb/tb_mul_div_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide built on one shared shift-add / restoring-divide datapath.
// Latency: a request is accepted at edge N. Result_o, Zero_o and Done_o are registered at edge N+33.
// Backpressure: none. Start_i is sampled only in IDLE or DONE. Busy_o is high while a request is in flight.
//
// Ports:
//   clk, reset             rising-edge clock; asynchronous active-high reset
//   Start_i, Op_i          request strobe; RV32M funct3 operation code
//   A_i, B_i               rs1 / rs2 operands
//   Busy_o, Done_o         in-flight flag; one-cycle completion pulse
//   Result_o, Zero_o       registered result and (Result_o == 0) flag; both hold until the next completion
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Start_i,
   input  logic [2:0]       Op_i,
   input  logic [WIDTH-1:0] A_i,
   input  logic [WIDTH-1:0] B_i,
   output logic             Busy_o,
   output logic             Done_o,
   output logic [WIDTH-1:0] Result_o,
   output logic             Zero_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]       state;
   logic [4:0]       cnt;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] opnd;    // multiplicand (mul) or divisor (div) magnitude
   logic [WIDTH-1:0] hi;      // product high half / partial remainder
   logic [WIDTH-1:0] lo;      // multiplier bits shifting out / dividend shifting into quotient
   logic [WIDTH-1:0] a_orig;  // unconverted A, returned by REM/REMU on divide-by-zero
   logic             b_zero;
   logic             ovf;
   logic             neg_q;   // product or quotient sign
   logic             neg_r;   // remainder sign

   // ---------------- request decode (used only at the accepting edge) ----------------
   logic             accept;
   logic             is_mul;
   logic             a_sgn;
   logic             b_sgn;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;

   always_comb begin
      accept = Start_i && ((state == S_IDLE) || (state == S_DONE));
      is_mul = ~Op_i[2];
      // MULHU is the only unsigned-A multiply; MULHSU and MULHU have unsigned B.
      a_sgn  = is_mul ? (Op_i[1:0] != 2'b11) : ~Op_i[0];
      b_sgn  = is_mul ? ~Op_i[1] : ~Op_i[0];
      a_neg  = a_sgn & A_i[WIDTH-1];
      b_neg  = b_sgn & B_i[WIDTH-1];
      a_mag  = a_neg ? (WIDTH'(0) - A_i) : A_i;
      b_mag  = b_neg ? (WIDTH'(0) - B_i) : B_i;
   end

   // ---------------- one iteration of the shared datapath ----------------
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH+1:0] div_diff;
   logic             div_ok;

   always_comb begin
      // Shift-add: conditionally add multiplicand to the high half, then shift {carry,hi,lo} right.
      mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
      // Restoring divide: shift the next dividend bit into the remainder and trial-subtract.
      div_shift = {hi, lo[WIDTH-1]};
      div_diff  = {1'b0, div_shift} - {2'b00, opnd};
      div_ok    = ~div_diff[WIDTH+1];
   end

   // ---------------- sign correction and special cases ----------------
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   quot_s;
   logic [WIDTH-1:0]   rem_s;
   logic [WIDTH-1:0]   fix_res;

   always_comb begin
      prod    = {hi, lo};
      prod_s  = neg_q ? ((2*WIDTH)'(0) - prod) : prod;
      quot_s  = neg_q ? (WIDTH'(0) - lo) : lo;
      rem_s   = neg_r ? (WIDTH'(0) - hi) : hi;
      fix_res = '0;
      case (op_q)
         3'b000:                 fix_res = prod_s[WIDTH-1:0];
         3'b001, 3'b010, 3'b011: fix_res = prod_s[2*WIDTH-1:WIDTH];
         3'b100, 3'b101: begin
            if (b_zero)                     fix_res = '1;
            else if (ovf && !op_q[0])       fix_res = {1'b1, {(WIDTH-1){1'b0}}};
            else                            fix_res = quot_s;
         end
         default: begin
            if (b_zero)                     fix_res = a_orig;
            else if (ovf && !op_q[0])       fix_res = '0;
            else                            fix_res = rem_s;
         end
      endcase
   end

   // ---------------- state and datapath registers ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         cnt      <= '0;
         op_q     <= '0;
         opnd     <= '0;
         hi       <= '0;
         lo       <= '0;
         a_orig   <= '0;
         b_zero   <= 1'b0;
         ovf      <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         Result_o <= '0;
         Zero_o   <= 1'b1;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (accept) begin
                  state  <= S_CALC;
                  cnt    <= '0;
                  op_q   <= Op_i;
                  opnd   <= is_mul ? a_mag : b_mag;
                  lo     <= is_mul ? b_mag : a_mag;
                  hi     <= '0;
                  a_orig <= A_i;
                  b_zero <= (B_i == '0);
                  ovf    <= (A_i == {1'b1, {(WIDTH-1){1'b0}}}) && (B_i == '1);
                  neg_q  <= a_neg ^ b_neg;
                  neg_r  <= a_neg;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_CALC: begin
               if (!op_q[2]) begin
                  hi <= mul_sum[WIDTH:1];
                  lo <= {mul_sum[0], lo[WIDTH-1:1]};
               end else begin
                  hi <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                  lo <= {lo[WIDTH-2:0], div_ok};
               end
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) state <= S_FIX;
            end
            default: begin  // S_FIX
               Result_o <= fix_res;
               Zero_o   <= (fix_res == '0);
               state    <= S_DONE;
            end
         endcase
      end
   end

   assign Busy_o = (state == S_CALC) || (state == S_FIX);
   assign Done_o = (state == S_DONE);

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors, handshake/reset sequences and random ops checked against an arithmetic model.
// Latency: every request expects Done_o exactly 33 edges after acceptance.
// Backpressure: Start_i is held during DONE once to check 34-cycle back-to-back acceptance.
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        Start_i;
   logic [2:0]  Op_i;
   logic [31:0] A_i;
   logic [31:0] B_i;
   logic        Busy_o;
   logic        Done_o;
   logic [31:0] Result_o;
   logic        Zero_o;

   int n_tests = 0;
   int n_fail  = 0;

   mul_div_unit #(.WIDTH(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .Start_i  (Start_i),
      .Op_i     (Op_i),
      .A_i      (A_i),
      .B_i      (B_i),
      .Busy_o   (Busy_o),
      .Done_o   (Done_o),
      .Result_o (Result_o),
      .Zero_o   (Zero_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Arithmetic model of RV32M semantics.
   function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0]        ea;
      logic [63:0]        eb;
      logic [63:0]        p;
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      sa = a;
      sb = b;
      ea = (op == 3'b011) ? {32'h0, a} : {{32{a[31]}}, a};
      eb = (op[1]) ? {32'h0, b} : {{32{b[31]}}, b};
      p  = ea * eb;
      case (op)
         3'b000: return p[31:0];
         3'b001, 3'b010, 3'b011: return p[63:32];
         3'b100: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return sa / sb;
         end
         3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'b110: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return sa % sb;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Starts a request (caller is 1 time unit after a rising edge) and waits up to 40 edges for Done_o.
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic zero, output int lat);
      Op_i = op; A_i = a; B_i = b; Start_i = 1'b1;
      @(posedge clk); #1;
      Start_i = 1'b0;
      lat = 0; res = 32'hDEAD_BEEF; zero = 1'bx;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (Done_o) begin
            lat = k; res = Result_o; zero = Zero_o;
            break;
         end
      end
   endtask

   task automatic count_dones(input int cycles, output int n);
      n = 0;
      for (int k = 0; k < cycles; k++) begin
         @(posedge clk); #1;
         if (Done_o) n++;
      end
   endtask

   vec_t        vecs[12];
   logic [31:0] res;
   logic        zero;
   int          lat;
   int          nd;
   logic [2:0]  rop;
   logic [31:0] ra;
   logic [31:0] rb;

   initial begin
      vecs[0]  = '{3'b000, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFA};
      vecs[1]  = '{3'b001, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF};
      vecs[2]  = '{3'b011, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002};
      vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD};
      vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF};
      vecs[6]  = '{3'b101, 32'hFFFF_FFF9, 32'd2,        32'h7FFF_FFFC};
      vecs[7]  = '{3'b100, 32'd5,         32'd0,        32'hFFFF_FFFF};
      vecs[8]  = '{3'b111, 32'd5,         32'd0,        32'h0000_0005};
      vecs[9]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
      vecs[10] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[11] = '{3'b110, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9};

      reset = 1'b1; Start_i = 1'b0; Op_i = '0; A_i = '0; B_i = '0;
      #3;
      check("reset_busy",   {31'b0, Busy_o}, 32'd0);
      check("reset_done",   {31'b0, Done_o}, 32'd0);
      check("reset_result", Result_o,        32'd0);
      check("reset_zero",   {31'b0, Zero_o}, 32'd1);
      #9 reset = 1'b0;
      @(posedge clk); #1;

      // Directed vectors.
      foreach (vecs[i]) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, zero, lat);
         check($sformatf("vec%0d_result", i), res, vecs[i].exp);
         check($sformatf("vec%0d_zero", i), {31'b0, zero}, {31'b0, (vecs[i].exp == 32'd0)});
         check($sformatf("vec%0d_latency", i), lat, 32'd33);
      end
      @(posedge clk); #1;

      // Operand changes and Start_i during CALC are ignored.
      Op_i = 3'b000; A_i = 32'd7; B_i = 32'd6; Start_i = 1'b1;
      @(posedge clk); #1;
      Start_i = 1'b0;
      repeat (5) @(posedge clk);
      #1 A_i = 32'd1000; Op_i = 3'b101; Start_i = 1'b1;
      @(posedge clk); #1 Start_i = 1'b0; A_i = 32'd3;
      lat = 0; res = 32'hDEAD_BEEF;
      for (int k = 7; k <= 40; k++) begin
         @(posedge clk); #1;
         if (Done_o) begin lat = k; res = Result_o; break; end
      end
      check("busy_ignore_result",  res, 32'd42);
      check("busy_ignore_latency", lat, 32'd33);
      @(posedge clk); #1;
      check("busy_ignore_idle", {31'b0, Busy_o}, 32'd0);
      count_dones(40, nd);
      check("busy_ignore_no_extra", nd, 32'd0);

      // Start_i held through DONE: second request accepted at the DONE edge.
      Op_i = 3'b000; A_i = 32'd11; B_i = 32'd13; Start_i = 1'b1;
      lat = 0;
      for (int k = 0; k <= 40; k++) begin
         @(posedge clk); #1;
         if (Done_o) begin lat = k; break; end
      end
      check("b2b_first_result", Result_o, 32'd143);
      A_i = 32'd100; B_i = 32'd7; Op_i = 3'b111;
      @(posedge clk); #1 Start_i = 1'b0;
      lat = 0;
      for (int k = 2; k <= 45; k++) begin
         @(posedge clk); #1;
         if (Done_o) begin lat = k; break; end
      end
      check("b2b_spacing", lat, 32'd34);
      check("b2b_second_result", Result_o, 32'd2);
      @(posedge clk); #1;

      // Random operations against the arithmetic model.
      for (int i = 0; i < 60; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 15));
            3: ra = 32'hFFFF_FFFF;
            default: ;
         endcase
         do_op(rop, ra, rb, res, zero, lat);
         check($sformatf("rand%0d_op%0d_a%08h_b%08h", i, rop, ra, rb), res, ref_model(rop, ra, rb));
         check($sformatf("rand%0d_latency", i), lat, 32'd33);
      end

      // Reset in the middle of CALC discards the request immediately.
      do_op(3'b000, 32'd9, 32'd9, res, zero, lat);
      check("pre_reset_result", res, 32'd81);
      Op_i = 3'b100; A_i = 32'd1000; B_i = 32'd10; Start_i = 1'b1;
      @(posedge clk); #1 Start_i = 1'b0;
      repeat (10) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("midreset_busy",   {31'b0, Busy_o}, 32'd0);
      check("midreset_done",   {31'b0, Done_o}, 32'd0);
      check("midreset_result", Result_o,        32'd0);
      check("midreset_zero",   {31'b0, Zero_o}, 32'd1);
      #4 reset = 1'b0;
      count_dones(45, nd);
      check("post_reset_no_done", nd, 32'd0);
      check("post_reset_idle", {31'b0, Busy_o}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
